pipe_hazard_unit: RTL

PIPE_HAZARD_UNIT -- requirements
Module: pipe_hazard_unit

---
 rtl/pipe_hazard_unit.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipe_hazard_unit.sv
// pipe_hazard_unit: hazard detection and forwarding-select unit for a 5-stage in-order pipeline.
// Tracks the register writers that currently sit in EX, MEM and WB and compares them against the
// source operands of the instruction in ID.
//
// Ports:
//   clk, rst        : rising-edge clock; synchronous active-high reset
//   enable          : pipeline advance; when low, every register holds
//   id_*            : the instruction in ID (sources, source-used mask, destination, write and load flags)
//   ex_flush        : a taken branch or jump resolved in EX; this squashes the ID instruction
//   stall           : combinational; hold the PC and the IF/ID register
//   bubble          : combinational; the entry that goes into EX on this edge is a NOP
//   ex_fwd_sel      : registered; 2 bits per operand (00 regfile, 01 EX/MEM, 10 MEM/WB, 11 WB bypass)
//   inflight        : {WB.valid, MEM.valid, EX.valid}
module pipe_hazard_unit #(
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int FWD_EN  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        id_valid,
  input  logic [NUM_SRC*ADDR_W-1:0]   id_src_addr,
  input  logic [NUM_SRC-1:0]          id_src_used,
  input  logic [ADDR_W-1:0]           id_dst_addr,
  input  logic                        id_reg_write,
  input  logic                        id_mem_read,
  input  logic                        ex_flush,
  output logic                        stall,
  output logic                        bubble,
  output logic [NUM_SRC*2-1:0]        ex_fwd_sel,
  output logic [2:0]                  inflight
);

  // Tracking entries. The load flag is only consulted while an entry is in EX. After that point
  // the loaded data can be forwarded like any other result, so MEM and WB do not keep the flag.
  logic              ex_vld_q, ex_wr_q, ex_ld_q;
  logic [ADDR_W-1:0] ex_dst_q;
  logic              mem_vld_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_dst_q;
  logic              wb_vld_q, wb_wr_q;
  logic [ADDR_W-1:0] wb_dst_q;
  logic [NUM_SRC*2-1:0] fwd_sel_q;

  logic              ex_vld_d, ex_wr_d, ex_ld_d;
  logic [ADDR_W-1:0] ex_dst_d;
  logic [NUM_SRC*2-1:0] fwd_sel_d;

  logic [NUM_SRC-1:0] hit_ex, hit_mem, hit_wb;
  logic               stall_raw;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    logic [ADDR_W-1:0] src;
    logic              rd;
    logic [1:0]        sel;

    assign src = id_src_addr[k*ADDR_W +: ADDR_W];
    // r0 is hardwired to zero, so a read of r0 never depends on an older writer.
    assign rd  = id_valid & id_src_used[k] & (src != '0);

    assign hit_ex[k]  = rd & ex_vld_q  & ex_wr_q  & (src == ex_dst_q);
    assign hit_mem[k] = rd & mem_vld_q & mem_wr_q & (src == mem_dst_q);
    assign hit_wb[k]  = rd & wb_vld_q  & wb_wr_q  & (src == wb_dst_q);

    // The youngest writer wins. An EX load cannot be forwarded yet: that case always stalls,
    // so here it simply falls through to the older entries.
    assign sel = (hit_ex[k] & ~ex_ld_q) ? 2'b01 :
                 hit_mem[k]             ? 2'b10 :
                 hit_wb[k]              ? 2'b11 : 2'b00;

    assign fwd_sel_d[2*k +: 2] = ((FWD_EN != 0) && !bubble) ? sel : 2'b00;
  end

  // With forwarding, only a load-use pair has to wait. Without forwarding, a reader waits
  // until its writer has left WB.
  assign stall_raw = (FWD_EN != 0) ? ((|hit_ex) & ex_ld_q)
                                   : (|(hit_ex | hit_mem | hit_wb));

  // A flush kills the ID instruction, so there is nothing left to hold.
  assign stall  = stall_raw & ~ex_flush & ~rst;
  assign bubble = (stall | ex_flush | ~id_valid) & ~rst;

  always_comb begin
    ex_vld_d = 1'b0;
    ex_dst_d = '0;
    ex_wr_d  = 1'b0;
    ex_ld_d  = 1'b0;
    if (!bubble) begin
      ex_vld_d = 1'b1;
      ex_dst_d = id_dst_addr;
      ex_wr_d  = id_reg_write;
      ex_ld_d  = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_vld_q  <= 1'b0;
      ex_dst_q  <= '0;
      ex_wr_q   <= 1'b0;
      ex_ld_q   <= 1'b0;
      mem_vld_q <= 1'b0;
      mem_dst_q <= '0;
      mem_wr_q  <= 1'b0;
      wb_vld_q  <= 1'b0;
      wb_dst_q  <= '0;
      wb_wr_q   <= 1'b0;
      fwd_sel_q <= '0;
    end else if (enable) begin
      wb_vld_q  <= mem_vld_q;
      wb_dst_q  <= mem_dst_q;
      wb_wr_q   <= mem_wr_q;
      mem_vld_q <= ex_vld_q;
      mem_dst_q <= ex_dst_q;
      mem_wr_q  <= ex_wr_q;
      ex_vld_q  <= ex_vld_d;
      ex_dst_q  <= ex_dst_d;
      ex_wr_q   <= ex_wr_d;
      ex_ld_q   <= ex_ld_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  assign ex_fwd_sel = fwd_sel_q;
  assign inflight   = {wb_vld_q, mem_vld_q, ex_vld_q};

endmodule
